// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues in-order reads for PC-stage addresses and delivers {instr, pc} to decode in order.
// Optional same-cycle response-to-decode bypass is enabled by defining IFQ_BYPASS_EN.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          pc_valid,
  input  logic [AW-1:0] pc,
  output logic          pc_ready,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  input  logic          flush,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  input  logic          dec_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {RUN, FLUSHING} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     slot_pc   [DEPTH];
  logic [DW-1:0]     slot_data [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [PW-1:0]     alloc_ptr, fill_ptr, rd_ptr;
  logic [CW-1:0]     alloc_cnt, outst_cnt, outst_nxt;
  logic              run, issue, resp_acc, fill, pop, head_filled, bypass_hit;

  // Reset gates the combinational handshakes so nothing is issued or delivered while it is held.
  assign run         = (state_q == RUN) && !reset;
  assign issue       = pc_valid && run && (alloc_cnt < CW'(DEPTH)) && !flush;
  assign pc_ready    = issue;
  assign imem_rd     = issue;
  assign imem_addr   = issue ? pc : '0;
  assign resp_acc    = imem_rvalid && (outst_cnt != '0) && !reset;
  assign fill        = resp_acc && run && !flush;
  assign head_filled = filled_q[rd_ptr];

`ifdef IFQ_BYPASS_EN
  // In-order fills mean fill_ptr == rd_ptr only when the head slot is the one awaiting data.
  assign bypass_hit  = fill && (fill_ptr == rd_ptr) && !head_filled;
`else
  assign bypass_hit  = 1'b0;
`endif

  assign instr_valid = run && !flush && (head_filled || bypass_hit);
  assign pop         = instr_valid && dec_ready;
  assign outst_nxt   = outst_cnt + CW'(issue) - CW'(resp_acc);

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (instr_valid) begin
      instr    = slot_data[rd_ptr];
      instr_pc = slot_pc[rd_ptr];
`ifdef IFQ_BYPASS_EN
      if (bypass_hit) instr = imem_rdata;
`endif
    end
  end

  // A bypassed pop sets and clears the same filled bit, netting to empty.
  always_comb begin
    filled_d = filled_q;
    if (issue) filled_d[alloc_ptr] = 1'b0;
    if (fill)  filled_d[fill_ptr]  = 1'b1;
    if (pop)   filled_d[rd_ptr]    = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (flush && (outst_nxt != '0)) state_d = FLUSHING;
      FLUSHING: if (outst_nxt == '0) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= RUN;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      alloc_cnt <= '0;
      outst_cnt <= '0;
      filled_q  <= '0;
    end else begin
      state_q   <= state_d;
      outst_cnt <= outst_nxt;
      if (flush) begin
        alloc_ptr <= '0;
        fill_ptr  <= '0;
        rd_ptr    <= '0;
        alloc_cnt <= '0;
        filled_q  <= '0;
      end else begin
        if (issue) alloc_ptr <= alloc_ptr + PW'(1);
        if (fill)  fill_ptr  <= fill_ptr + PW'(1);
        if (pop)   rd_ptr    <= rd_ptr + PW'(1);
        alloc_cnt <= alloc_cnt + CW'(issue) - CW'(pop);
        filled_q  <= filled_d;
      end
    end
  end

  // Slot payload needs no reset: filled bits qualify every read.
  always_ff @(posedge Clk) begin
    if (issue) slot_pc[alloc_ptr]  <= pc;
    if (fill)  slot_data[fill_ptr] <= imem_rdata;
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: in-order memory model with programmable latency and an output scoreboard.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef IFQ_BYPASS_EN
  localparam int BYP_ADD = 0;
`else
  localparam int BYP_ADD = 1;
`endif

  logic          Clk = 1'b0;
  logic          reset = 1'b1;
  logic          pc_valid = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          pc_ready, imem_rd;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          flush = 1'b0;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          dec_ready = 1'b0;

  logic          m_rvalid = 1'b0, spur_rvalid = 1'b0;
  logic [DW-1:0] m_rdata = '0, spur_rdata = '0;
  assign imem_rvalid = m_rvalid | spur_rvalid;
  assign imem_rdata  = m_rvalid ? m_rdata : spur_rdata;

  int cyc = 0;
  int lat = 1;
  int checks = 0;
  int failures = 0;

  logic [AW-1:0] mq_addr[$];
  int            mq_due[$];
  logic [AW-1:0] obs_pc[$];
  logic [DW-1:0] obs_data[$];
  int            obs_cyc[$];
  logic [AW-1:0] exp_pc[$];

  instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk(Clk), .reset(reset), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .flush(flush), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .dec_ready(dec_ready)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  // Request logger and delivery monitor, sampled mid-cycle.
  always @(negedge Clk) begin
    if (imem_rd) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + lat);
    end
    if (instr_valid && dec_ready) begin
      obs_pc.push_back(instr_pc);
      obs_data.push_back(instr);
      obs_cyc.push_back(cyc);
    end
  end

  always @(posedge Clk) begin
    #1;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      m_rvalid = 1'b1;
      m_rdata  = memfn(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      m_rvalid = 1'b0;
      m_rdata  = '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_sb();
    obs_pc.delete();
    obs_data.delete();
    obs_cyc.delete();
    exp_pc.delete();
  endtask

  task automatic wait_obs(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (obs_pc.size() >= n) break;
      tick();
    end
    if (obs_pc.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_valid = 1'b1; pc = 32'h1234; dec_ready = 1'b1;
    tick(); tick();
    @(negedge Clk);
    checks++;
    if (pc_ready !== 1'b0) begin failures++; $display("FAIL reset_pc_ready: got %b want 0", pc_ready); end
    checks++;
    if ({imem_rd, imem_addr, instr_valid, instr, instr_pc} !== '0)
      begin failures++; $display("FAIL reset_outputs: rd=%b addr=%h iv=%b instr=%h ipc=%h want all 0", imem_rd, imem_addr, instr_valid, instr, instr_pc); end
    tick();
    reset = 1'b0; pc_valid = 1'b0; dec_ready = 1'b0;
    clear_sb();
  endtask

  task automatic test_stream();
    bit ok;
    int t0;
    lat = 1; dec_ready = 1'b1;
    clear_sb();
    t0 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pc_valid = 1'b1; pc = AW'(i);
      if (i == 0) t0 = cyc;
      exp_pc.push_back(AW'(i));
      @(negedge Clk);
      checks++;
      if (pc_ready !== 1'b1) begin failures++; $display("FAIL stream_pc_ready[%0d]: got %b want 1", i, pc_ready); end
    end
    tick();
    pc_valid = 1'b0;
    wait_obs(8, 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stream_timeout: got %0d deliveries want 8", obs_pc.size()); end
    for (int i = 0; i < 8 && i < obs_pc.size(); i++) begin
      checks++;
      if (obs_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL stream_pc[%0d]: got %h want %h", i, obs_pc[i], exp_pc[i]); end
      checks++;
      if (obs_data[i] !== memfn(exp_pc[i])) begin failures++; $display("FAIL stream_data[%0d]: got %h want %h", i, obs_data[i], memfn(exp_pc[i])); end
      checks++;
      if (obs_cyc[i] != t0 + i + lat + BYP_ADD) begin failures++; $display("FAIL stream_cycle[%0d]: got %0d want %0d", i, obs_cyc[i], t0 + i + lat + BYP_ADD); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int accepted;
    lat = 1; dec_ready = 1'b0;
    clear_sb();
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      pc_valid = (accepted < 6); pc = AW'(100 + accepted);
      @(negedge Clk);
      if (pc_valid && pc_ready) accepted++;
    end
    checks++;
    if (accepted != 4) begin failures++; $display("FAIL bp_issued: got %0d want 4", accepted); end
    checks++;
    if (pc_ready !== 1'b0) begin failures++; $display("FAIL bp_pc_ready_full: got %b want 0", pc_ready); end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== AW'(100))
      begin failures++; $display("FAIL bp_head: valid=%b pc=%h want valid=1 pc=64", instr_valid, instr_pc); end
    for (int i = 0; i < 6; i++) exp_pc.push_back(AW'(100 + i));
    for (int c = 0; c < 30 && accepted < 6; c++) begin
      tick();
      dec_ready = 1'b1;
      pc_valid = (accepted < 6); pc = AW'(100 + accepted);
      @(negedge Clk);
      if (pc_valid && pc_ready) accepted++;
    end
    tick();
    pc_valid = 1'b0;
    wait_obs(6, 30, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_timeout: got %0d deliveries want 6", obs_pc.size()); end
    for (int i = 0; i < 6 && i < obs_pc.size(); i++) begin
      checks++;
      if (obs_pc[i] !== exp_pc[i] || obs_data[i] !== memfn(exp_pc[i]))
        begin failures++; $display("FAIL bp_order[%0d]: got pc=%h data=%h want pc=%h data=%h", i, obs_pc[i], obs_data[i], exp_pc[i], memfn(exp_pc[i])); end
    end
  endtask

  task automatic test_flush_inflight();
    bit ok, resumed;
    lat = 3; dec_ready = 1'b1;
    clear_sb();
    for (int i = 0; i < 3; i++) begin
      tick();
      pc_valid = 1'b1; pc = AW'(10 + i);
      @(negedge Clk);
      checks++;
      if (pc_ready !== 1'b1) begin failures++; $display("FAIL fl_issue[%0d]: got %b want 1", i, pc_ready); end
    end
    tick();
    flush = 1'b1; pc_valid = 1'b1; pc = AW'(40);
    @(negedge Clk);
    checks++;
    if (instr_valid !== 1'b0 || pc_ready !== 1'b0)
      begin failures++; $display("FAIL fl_gate: valid=%b ready=%b want 0 0", instr_valid, pc_ready); end
    tick();
    flush = 1'b0;
    resumed = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (pc_ready) begin resumed = 1'b1; break; end
      checks++;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL fl_drop_valid: got %b want 0", instr_valid); end
      tick();
    end
    checks++;
    if (!resumed) begin failures++; $display("FAIL fl_resume: pc_ready got 0 want 1"); end
    checks++;
    if (obs_pc.size() != 0) begin failures++; $display("FAIL fl_no_delivery: got %0d deliveries want 0", obs_pc.size()); end
    tick();
    pc_valid = 1'b0;
    exp_pc.push_back(AW'(40));
    wait_obs(1, 20, ok);
    checks++;
    if (!ok || obs_pc[0] !== exp_pc[0] || obs_data[0] !== memfn(exp_pc[0]))
      begin failures++; $display("FAIL fl_after_pc40: ok=%b got %0d deliveries, first pc=%h want 28", ok, obs_pc.size(), (obs_pc.size() > 0) ? obs_pc[0] : 'x); end
    lat = 1;
  endtask

  task automatic test_flush_collide();
    bit ok;
    lat = 1; dec_ready = 1'b0;
    clear_sb();
    tick(); pc_valid = 1'b1; pc = AW'(20);
    tick(); pc = AW'(21);
    tick(); pc_valid = 1'b0; flush = 1'b1; dec_ready = 1'b1;
    @(negedge Clk);
    checks++;
    if (imem_rvalid !== 1'b1) begin failures++; $display("FAIL col_resp_present: got %b want 1", imem_rvalid); end
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL col_valid_gate: got %b want 0", instr_valid); end
    tick();
    flush = 1'b0; pc_valid = 1'b1; pc = AW'(22);
    @(negedge Clk);
    checks++;
    if (pc_ready !== 1'b1) begin failures++; $display("FAIL col_run_resumes: pc_ready got %b want 1", pc_ready); end
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL col_queue_empty: valid got %b want 0", instr_valid); end
    tick();
    pc_valid = 1'b0;
    exp_pc.push_back(AW'(22));
    wait_obs(1, 10, ok);
    checks++;
    if (!ok || obs_pc[0] !== exp_pc[0] || obs_data[0] !== memfn(exp_pc[0]))
      begin failures++; $display("FAIL col_next: ok=%b got %0d deliveries, first pc=%h want 16", ok, obs_pc.size(), (obs_pc.size() > 0) ? obs_pc[0] : 'x); end
  endtask

  task automatic test_spurious();
    bit ok;
    int t0;
    lat = 1; dec_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    clear_sb();
    tick();
    spur_rvalid = 1'b1; spur_rdata = 32'hDEAD_BEEF;
    @(negedge Clk);
    checks++;
    if (instr_valid !== 1'b0) begin failures++; $display("FAIL spur_valid: got %b want 0", instr_valid); end
    tick();
    spur_rvalid = 1'b0; pc_valid = 1'b1; pc = AW'(50);
    t0 = cyc;
    @(negedge Clk);
    checks++;
    if (instr_valid !== 1'b0 || pc_ready !== 1'b1)
      begin failures++; $display("FAIL spur_after: valid=%b ready=%b want 0 1", instr_valid, pc_ready); end
    tick();
    pc_valid = 1'b0;
    exp_pc.push_back(AW'(50));
    wait_obs(1, 10, ok);
    checks++;
    if (!ok || obs_pc[0] !== exp_pc[0] || obs_data[0] !== memfn(exp_pc[0]) || obs_cyc[0] != t0 + lat + BYP_ADD)
      begin failures++; $display("FAIL spur_next: ok=%b got %0d deliveries, first pc=%h want 32 at cycle %0d", ok, obs_pc.size(), (obs_pc.size() > 0) ? obs_pc[0] : 'x, t0 + lat + BYP_ADD); end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    int t0;
    lat = 1; dec_ready = 1'b1;
    clear_sb();
    for (int i = 0; i < 4; i++) begin
      tick();
      pc_valid = 1'b1; pc = AW'(60 + i);
    end
    tick();
    reset = 1'b1; pc = AW'(64);
    @(negedge Clk);
    checks++;
    if (pc_ready !== 1'b0 || imem_rd !== 1'b0)
      begin failures++; $display("FAIL rst_mid_gate: ready=%b rd=%b want 0 0", pc_ready, imem_rd); end
    tick();
    reset = 1'b0; pc_valid = 1'b0;
    @(negedge Clk);
    checks++;
    if ({pc_ready, imem_rd, imem_addr, instr_valid, instr, instr_pc} !== '0)
      begin failures++; $display("FAIL rst_mid_outputs: ready=%b rd=%b addr=%h iv=%b instr=%h ipc=%h want all 0", pc_ready, imem_rd, imem_addr, instr_valid, instr, instr_pc); end
    tick(); tick(); tick();
    clear_sb();
    pc_valid = 1'b1; pc = AW'(0);
    t0 = cyc;
    tick();
    pc_valid = 1'b0;
    exp_pc.push_back(AW'(0));
    wait_obs(1, 10, ok);
    checks++;
    if (!ok || obs_pc[0] !== exp_pc[0] || obs_data[0] !== memfn(exp_pc[0]) || obs_cyc[0] != t0 + lat + BYP_ADD)
      begin failures++; $display("FAIL rst_mid_pc0: ok=%b got %0d deliveries, first pc=%h want 0 at cycle %0d", ok, obs_pc.size(), (obs_pc.size() > 0) ? obs_pc[0] : 'x, t0 + lat + BYP_ADD); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_inflight();
    test_flush_collide();
    test_spurious();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
